// File: rtl/watermark_pkg.sv
// ============================================================================
// watermark_pkg : shared widths, ROM generation and state encoding for mu_recover
// Rev 1.0
// ============================================================================
`default_nettype none

package watermark_pkg;

    localparam int C_MU_SIZE   = 10;
    localparam int C_W_SIZE    = 12;
    localparam int C_ROM_DEPTH = 64;
    localparam int C_ROM_IDX_W = 6;

    // 2^(-1/256) in Q32; ROM entries are successive powers of this step.
    localparam logic [63:0] C_STEP_Q32 = 64'd4283353945;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // floor(d^2 * 256) from a d^2 product whose LSB weighs 2^-(2*mu_size).
    function automatic int idx_shift(input int mu_size);
        return 2 * mu_size - 8;
    endfunction

    // round(2^(-idx/256) * 2^(w_size-1)), elaborated in integer arithmetic.
    function automatic logic [31:0] rom_entry(input int idx, input int w_size);
        logic [63:0] acc;
        acc = 64'h1_0000_0000;
        for (int k = 0; k < idx; k++) begin
            acc = ((acc * C_STEP_Q32) + 64'h8000_0000) >> 32;
        end
        acc = ((acc << (w_size - 1)) + 64'h8000_0000) >> 32;
        return acc[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gauss_weight_rom.sv
// ============================================================================
// gauss_weight_rom : combinational d_bits -> 2^(-d^2) weight (square, shift, ROM)
// Rev 1.0
// ============================================================================
`default_nettype none

module gauss_weight_rom
    import watermark_pkg::*;
#(
    parameter int MU_SIZE = C_MU_SIZE,
    parameter int W_SIZE  = C_W_SIZE
) (
    input  logic [MU_SIZE-2:0] d_bits_i,
    output logic [W_SIZE-1:0]  weight_o
);

    localparam int C_SQ_W      = 2 * (MU_SIZE - 1);
    localparam int C_IDX_SHIFT = idx_shift(MU_SIZE);

    logic [C_SQ_W-1:0]      w_d_ext;
    logic [C_SQ_W-1:0]      w_sq;
    logic [C_ROM_IDX_W-1:0] w_idx;
    logic [W_SIZE-1:0]      w_rom [C_ROM_DEPTH];

    assign w_d_ext = C_SQ_W'(d_bits_i);
    assign w_sq    = w_d_ext * w_d_ext;
    assign w_idx   = w_sq[C_IDX_SHIFT +: C_ROM_IDX_W];

    for (genvar g = 0; g < C_ROM_DEPTH; g++) begin : g_rom
        assign w_rom[g] = W_SIZE'(rom_entry(g, W_SIZE));
    end

    assign weight_o = w_rom[w_idx];

endmodule

`default_nettype wire

// File: rtl/mu_recover.sv
// ============================================================================
// mu_recover : SAR inverse of w(mu) = 2^(-(mu-0.5)^2) on the mu >= 0.5 branch
// Rev 1.0
// ============================================================================
`default_nettype none

module mu_recover
    import watermark_pkg::*;
#(
    parameter int MU_SIZE = C_MU_SIZE,
    parameter int W_SIZE  = C_W_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W_SIZE-1:0]  w_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [MU_SIZE-1:0] mu_out,
    output logic               err,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int                C_DW    = MU_SIZE - 1;
    localparam int                C_BIT_W = $clog2(MU_SIZE);
    localparam logic [W_SIZE-1:0] C_W_ONE = W_SIZE'(1) << (W_SIZE - 1);

    state_e               state_q, state_d;
    logic [W_SIZE-1:0]    w_q, w_d;
    logic [C_DW-1:0]      dist_q, dist_d;
    logic [C_BIT_W-1:0]   bit_q, bit_d;
    logic [MU_SIZE-1:0]   mu_q, mu_d;
    logic                 err_q, err_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [C_DW-1:0]      w_trial;
    logic [W_SIZE-1:0]    w_weight;
    logic [C_DW-1:0]      w_dist_nxt;
    logic                 w_no_sol;

    assign w_trial    = dist_q | (C_DW'(1) << bit_q);
    assign w_dist_nxt = (w_weight >= w_q) ? w_trial : dist_q;
    assign w_no_sol   = (w_q > C_W_ONE);

    gauss_weight_rom #(
        .MU_SIZE (MU_SIZE),
        .W_SIZE  (W_SIZE)
    ) u_rom (
        .d_bits_i (w_trial),
        .weight_o (w_weight)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        dist_d  = dist_q;
        bit_d   = bit_q;
        mu_d    = mu_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    w_d     = w_in;
                    dist_d  = '0;
                    bit_d   = C_BIT_W'(MU_SIZE - 2);
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                dist_d = w_dist_nxt;
                if (bit_q == '0) begin
                    state_d = ST_DONE;
                    err_d   = w_no_sol;
                    mu_d    = w_no_sol ? {1'b1, {C_DW{1'b0}}} : {1'b1, w_dist_nxt};
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake flags are registered so both read 0 in the cycle after reset.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            dist_q      <= '0;
            bit_q       <= '0;
            mu_q        <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            dist_q      <= dist_d;
            bit_q       <= bit_d;
            mu_q        <= mu_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mu_out    = mu_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mu_recover.sv
// ============================================================================
// tb_mu_recover : randomized self-checking bench for mu_recover
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mu_recover;

    localparam int MU = 10;
    localparam int WS = 12;

    logic          clk;
    logic          rst_n;
    logic [WS-1:0] w_in;
    logic          in_valid;
    logic          in_ready;
    logic [MU-1:0] mu_out;
    logic          err;
    logic          out_valid;
    logic          out_ready;

    int n_vec;
    int n_err;
    int rom_ref [64];

    mu_recover #(.MU_SIZE(MU), .W_SIZE(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_in      (w_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mu_out    (mu_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Largest d in [0,511] whose weight still reaches w; no solution above w(0.5).
    function automatic void model(input int w, output int mu, output int e);
        mu = 512;
        e  = (w > rom_ref[0]) ? 1 : 0;
        if (e == 0) begin
            for (int d = 0; d < 512; d++) begin
                if (rom_ref[(d * d) / 4096] >= w) mu = 512 + d;
            end
        end
    endfunction

    task automatic do_txn(input int w, input int stall, output int mu_obs,
                          output int err_obs, output time t_acc);
        int guard;
        int cnt;
        int mu_exp;
        int e_exp;
        model(w, mu_exp, e_exp);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", in_ready, 1);
        in_valid  = 1'b1;
        w_in      = WS'(w);
        out_ready = (stall == 0);
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        in_valid = 1'b0;
        w_in     = WS'($urandom);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        // Counting the accept cycle as the first, out_valid shows in cycle MU.
        chk("latency", cnt, MU - 1);
        chk("mu_model", mu_out, mu_exp);
        chk("err_model", err, e_exp);
        mu_obs  = mu_out;
        err_obs = err;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            w_in     = WS'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_mu", mu_out, mu_exp);
            chk("hold_err", err, e_exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("exit_valid", out_valid, 0);
        chk("exit_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int   mu_o;
        int   e_o;
        time  t0;
        time  t_prev;
        int   w;
        int   bad;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) begin
            rom_ref[i] = $rtoi($pow(2.0, -real'(i) / 256.0) * 2048.0 + 0.5);
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        w_in      = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mu", mu_out, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        do_txn(2048, 0, mu_o, e_o, t0);
        chk("mu_2048", mu_o, 575);
        chk("err_2048", e_o, 0);
        do_txn(2042, 0, mu_o, e_o, t0);
        chk("mu_2042", mu_o, 602);
        do_txn(0, 0, mu_o, e_o, t0);
        chk("mu_0", mu_o, 1023);
        chk("err_0", e_o, 0);
        do_txn(2049, 0, mu_o, e_o, t0);
        chk("mu_2049", mu_o, 512);
        chk("err_2049", e_o, 1);
        do_txn(1900, 5, mu_o, e_o, t0);

        // Reset pulse in the middle of a search must leave no result behind.
        in_valid  = 1'b1;
        w_in      = 12'd1800;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        @(negedge clk);
        chk("midrst_ready2", in_ready, 1);
        bad = 0;
        repeat (14) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        chk("midrst_stale", bad, 0);

        t_prev = 0;
        for (int n = 0; n < 20; n++) begin
            w = $urandom_range(2048, 1722);
            do_txn(w, 0, mu_o, e_o, t0);
            if (n > 0) chk("period", 32'((t0 - t_prev) / 10), MU + 1);
            t_prev = t0;
        end

        for (int n = 0; n < 10; n++) begin
            do_txn($urandom_range(4095, 0), n % 3, mu_o, e_o, t0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
